frame_scanout: RTL

FRAME_SCANOUT -- requirements
Module: frame_scanout

---
 rtl/frame_scanout.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/frame_scanout.sv
// Purpose : VGA 640x480 raster scan-out; generates pixel strobe, DrawX/DrawY, syncs, blank, palette RGB.
// Latency : sync/blank/RGB for pixel (x,y) appear one pixel period after DrawX/DrawY present (x,y).
// Backpressure: none, free-running raster; colorcode must be valid combinationally for the current DrawX/DrawY.
//
// Ports:
//   Clk, Reset_n (async, active-low)
//   colorcode   [5:0] palette index for the current DrawX/DrawY (from the renderer)
//   DrawX/DrawY [9:0] registered scan position
//   pix_ce            pixel-advance strobe, one Clk in every PIX_DIV
//   VGA_HS/VGA_VS     active-low syncs; VGA_BLANK_N high in the visible area
//   VGA_R/G/B   [7:0] pixel colour
//   frame_tick        one-Clk pulse on entry to vertical blank
//
// The timing parameters beyond PIX_DIV default to standard 640x480@60 and only
// need overriding for a non-standard raster.
module frame_scanout #(
    parameter int PIX_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [5:0] colorcode,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pix_ce,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_tick
);

    localparam int DIV_W = $clog2(PIX_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    localparam logic [9:0] H_LAST       = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VIS);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);

    localparam logic [9:0] V_LAST       = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_VIS_END    = 10'(V_VIS);
    localparam logic [9:0] V_VIS_LAST   = 10'(V_VIS - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;

    logic       hs_raw;
    logic       vs_raw;
    logic       vis_raw;

    logic [5:0] code_q;
    logic       hs_q;
    logic       vs_q;
    logic       vis_q;

    logic [23:0] pal_rgb;
    logic [23:0] rgb;

    // Pixel clock-enable divider
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Decoded from the counter register so pix_ce is forced low while in reset.
    assign pix_ce = (div_cnt == DIV_LAST);

    // Raster position counters
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            DrawX <= '0;
            DrawY <= '0;
        end else if (pix_ce) begin
            if (DrawX == H_LAST) begin
                DrawX <= '0;
                DrawY <= (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
            end else begin
                DrawX <= DrawX + 10'd1;
            end
        end
    end

    // Pulse on the very pixel edge that steps from the last visible line into
    // the vertical front porch; gated by pix_ce so it lasts exactly one Clk.
    assign frame_tick = pix_ce && (DrawX == H_LAST) && (DrawY == V_VIS_LAST);

    // Raw timing decode of the current (pre-edge) position
    assign hs_raw  = (DrawX >= H_SYNC_FIRST) && (DrawX <= H_SYNC_LAST);
    assign vs_raw  = (DrawY >= V_SYNC_FIRST) && (DrawY <= V_SYNC_LAST);
    assign vis_raw = (DrawX < H_VIS_END) && (DrawY < V_VIS_END);

    // Stage 1: colour code and timing flags of the pixel just scanned,
    // captured together so colour and syncs stay aligned.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            code_q <= '0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            vis_q  <= 1'b0;
        end else if (pix_ce) begin
            code_q <= colorcode;
            hs_q   <= hs_raw;
            vs_q   <= vs_raw;
            vis_q  <= vis_raw;
        end
    end

    // Palette lookup
    always_comb begin
        pal_rgb = 24'h000000;
        case (code_q)
            6'd0:    pal_rgb = 24'hFFFFFF;
            6'd1:    pal_rgb = 24'h000000;
            6'd2:    pal_rgb = 24'h27B212;
            6'd3:    pal_rgb = 24'hD80222;
            6'd4:    pal_rgb = 24'h5DB1F0;
            6'd5:    pal_rgb = 24'hF1FF0A;
            6'd6:    pal_rgb = 24'hB2B2B0;
            6'd7:    pal_rgb = 24'hF27A00;
            6'd8:    pal_rgb = 24'h663300;
            6'd9:    pal_rgb = 24'h8600B3;
            6'd10:   pal_rgb = 24'h000066;
            6'd11:   pal_rgb = 24'hFFFFFF;
            6'd12:   pal_rgb = 24'h70F248;
            6'd13:   pal_rgb = 24'hB2B2B0;
            default: pal_rgb = 24'h000000;
        endcase
    end

    // Stage 2: outputs driven straight from the stage-1 registers, so every
    // output follows reset immediately and they share one pixel of latency.
    assign rgb         = vis_q ? pal_rgb : 24'h000000;
    assign VGA_R       = rgb[23:16];
    assign VGA_G       = rgb[15:8];
    assign VGA_B       = rgb[7:0];
    assign VGA_HS      = ~hs_q;
    assign VGA_VS      = ~vs_q;
    assign VGA_BLANK_N = vis_q;

endmodule
